state_flag_tracker: RTL and testbench
=====================================

Name: state_flag_tracker

Overview:
- Registered, parametrised successor to the team's combinational state-to-flag decoder.
- Holds a current state and accepts state updates over a valid/ready handshake.
- Decodes each state to a flag through a parameter table, and detects illegal states instead of driving X.
- On an illegal update it forces a safe state, raises error status, and runs a timed recovery sequence before accepting updates again.

Parameters:
- SW, 2, state width in bits; table depth is 2**SW.
- FW, 2, flag width in bits.
- LEGAL_MASK, 4'b1011, bit i set means state i is legal; width 2**SW.
- FLAG_TABLE, 8'h0A, flag for state i at [i*FW +: FW]; default gives 0->2'b10, 1->2'b10, 3->2'b00.
- SAFE_STATE, 0, state forced on reset and on an illegal update; must be legal.
- ERR_FLAG, 2'b11, flag driven while in fault or recovery.
- RECOVER_CYCLES, 3, length of the recovery phase in cycles; must be >= 1.
- CW, 4, error counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- upd_valid  in  1  update request.
- upd_state  in  SW  requested next state.
- upd_ready  out  1  block can accept an update this cycle.
- err_clr  in  1  clears err_sticky and err_count.
- curr_state  out  SW  registered current state.
- flag  out  FW  registered decoded flag.
- illegal_pulse  out  1  one-cycle strobe when an illegal update is accepted.
- err_sticky  out  1  set on an illegal update, held until err_clr.
- err_count  out  CW  saturating count of illegal updates.
- busy  out  1  high in FAULT or RECOVER.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - curr_state=SAFE_STATE, flag=FLAG_TABLE[SAFE_STATE], fsm=RUN.
  - upd_ready=1, busy=0, illegal_pulse=0, err_sticky=0, err_count=0.
- FSM states: RUN, FAULT, RECOVER. upd_ready=(fsm==RUN); busy is its inverse. Both come from registered state only.
- Handshake:
  - An update is accepted when upd_valid && upd_ready at a rising edge.
  - upd_valid while upd_ready=0 is ignored, not queued; upstream holds valid/data until accepted.
  - No combinational path from inputs to outputs.
- RUN, legal accept (LEGAL_MASK[upd_state]=1):
  - curr_state<=upd_state and flag<=FLAG_TABLE[upd_state] on the same edge, i.e. 1-cycle latency.
  - Back-to-back accepts every cycle are allowed.
- RUN, illegal accept:
  - curr_state<=SAFE_STATE, flag<=ERR_FLAG, illegal_pulse<=1 for exactly one cycle.
  - err_sticky<=1; err_count increments, saturating at all-ones.
  - fsm->FAULT.
- FAULT: lasts exactly 1 cycle; loads the recovery counter with RECOVER_CYCLES-1; fsm->RECOVER.
- RECOVER:
  - The counter decrements each cycle.
  - On the edge where the counter is 0: fsm->RUN and flag<=FLAG_TABLE[SAFE_STATE].
  - Net effect: after an illegal accept, flag=ERR_FLAG and upd_ready=0 for exactly RECOVER_CYCLES+1 cycles.
- Table lookup: the flag entry for an illegal index is never used. An unlisted state can never reach the flag output.
- err_clr:
  - Synchronous; clears err_sticky and err_count next edge.
  - If err_clr and an illegal accept occur in the same cycle, the illegal accept wins: err_sticky=1, err_count=1.
  - err_clr has no effect on the FSM, curr_state or flag.
- Reset mid-FAULT or mid-RECOVER: immediately returns to the reset values above; the recovery counter is cleared.
- X-propagation: an upd_state containing X or Z is treated as illegal in simulation. Synthesis needs no special logic.

Decomposition:
- Package state_flag_pkg:
  - fsm enum typedef {RUN, FAULT, RECOVER}.
  - Default LEGAL_MASK and FLAG_TABLE constants.
  - ERR_FLAG default.
  - A function that extracts a table entry.
- Sub-module state_flag_decode: purely combinational. Inputs are the state index; outputs are the legal bit and the table flag, parameterised by SW, FW, LEGAL_MASK and FLAG_TABLE. It is instantiated once on the upd_state path.

Test Plan:
- Reset, then legal sequence 00, 01, 11 with upd_valid each cycle -> flag 10, 10, 00 one cycle after each accept; upd_ready stays 1; err_count=0.
- Illegal update 10 in RUN -> next cycle: curr_state=00, flag=11, illegal_pulse=1 for 1 cycle, err_sticky=1, err_count=1. upd_ready=0 for exactly 4 cycles (RECOVER_CYCLES=3), then flag=10 and upd_ready=1.
- upd_valid=1 with upd_state=11 held during recovery -> not accepted until upd_ready=1, then accepted on the first ready cycle; flag=00 one cycle later.
- Sixteen illegal updates (waiting out each recovery) with CW=4 -> err_count saturates at 4'hF and stays there; err_clr then gives err_sticky=0, err_count=0.
- err_clr asserted in the same cycle as an illegal accept -> err_sticky=1, err_count=1.
- rst_n asserted asynchronously two cycles into RECOVER -> outputs go to reset values immediately, without waiting for clk. After release, a legal update 01 is accepted on the first cycle and flag=10.

Source files
------------

// File: rtl/state_flag_tracker_pkg.sv
// Shared types and defaults for the registered state-to-flag tracker.
package state_flag_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FAULT   = 2'd1,
    RECOVER = 2'd2
  } fsm_e;

  localparam int         DEF_SW         = 2;
  localparam int         DEF_FW         = 2;
  localparam logic [3:0] DEF_LEGAL_MASK = 4'b1011;
  localparam logic [7:0] DEF_FLAG_TABLE = 8'h0A;
  localparam logic [1:0] DEF_ERR_FLAG   = 2'b11;

  // Widest flag table the helper below can address; tables are zero-extended to it.
  localparam int TBL_MAX_W = 64;

  // Returns entry idx of a packed table of fw-bit fields, right-aligned.
  function automatic logic [31:0] tbl_entry(input logic [TBL_MAX_W-1:0] tbl,
                                            input int idx, input int fw);
    logic [TBL_MAX_W-1:0] sh;
    sh = tbl >> (idx * fw);
    return 32'(sh) & ((32'd1 << fw) - 32'd1);
  endfunction

endpackage

// File: rtl/state_flag_tracker_if.sv
// Update handshake and status bundle of the state/flag tracker.
interface state_flag_tracker_if #(
  parameter int SW = 2,
  parameter int FW = 2,
  parameter int CW = 4
);
  logic          upd_valid;
  logic [SW-1:0] upd_state;
  logic          upd_ready;
  logic          err_clr;
  logic [SW-1:0] curr_state;
  logic [FW-1:0] flag;
  logic          illegal_pulse;
  logic          err_sticky;
  logic [CW-1:0] err_count;
  logic          busy;

  modport master (
    output upd_valid, upd_state, err_clr,
    input  upd_ready, curr_state, flag, illegal_pulse, err_sticky, err_count, busy
  );

  modport slave (
    input  upd_valid, upd_state, err_clr,
    output upd_ready, curr_state, flag, illegal_pulse, err_sticky, err_count, busy
  );
endinterface

// File: rtl/state_flag_tracker_decode.sv
// Combinational state decode: legality bit plus table flag.
// The compare-per-entry form keeps X/Z indices illegal in simulation,
// and an illegal index always yields a zero flag, never its table entry.
module state_flag_decode
  import state_flag_pkg::*;
#(
  parameter int                    SW         = DEF_SW,
  parameter int                    FW         = DEF_FW,
  parameter logic [2**SW-1:0]      LEGAL_MASK = DEF_LEGAL_MASK,
  parameter logic [FW*(2**SW)-1:0] FLAG_TABLE = DEF_FLAG_TABLE
) (
  input  logic [SW-1:0] state_idx,
  output logic          legal,
  output logic [FW-1:0] flag
);

  // Match the index against every table slot; only legal slots may drive the flag.
  always_comb begin
    legal = 1'b0;
    flag  = '0;
    for (int i = 0; i < 2**SW; i++) begin
      if ((state_idx == SW'(i)) && LEGAL_MASK[i]) begin
        legal = 1'b1;
        flag  = FW'(tbl_entry(TBL_MAX_W'(FLAG_TABLE), i, FW));
      end
    end
  end

endmodule

// File: rtl/state_flag_tracker.sv
// Registered state tracker: accepts state updates over valid/ready,
// decodes them to flags, and on an illegal update forces the safe state
// and runs a timed recovery before accepting updates again.
module state_flag_tracker
  import state_flag_pkg::*;
#(
  parameter int                    SW             = DEF_SW,
  parameter int                    FW             = DEF_FW,
  parameter logic [2**SW-1:0]      LEGAL_MASK     = DEF_LEGAL_MASK,
  parameter logic [FW*(2**SW)-1:0] FLAG_TABLE     = DEF_FLAG_TABLE,
  parameter int                    SAFE_STATE     = 0,
  parameter logic [FW-1:0]         ERR_FLAG       = DEF_ERR_FLAG,
  parameter int                    RECOVER_CYCLES = 3,
  parameter int                    CW             = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  state_flag_tracker_if.slave bus
);

  localparam int            RCW       = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [FW-1:0] SAFE_FLAG = FW'(tbl_entry(TBL_MAX_W'(FLAG_TABLE), SAFE_STATE, FW));
  localparam logic [SW-1:0] SAFE_IDX  = SW'(SAFE_STATE);
  localparam logic [RCW-1:0] RCNT_LOAD = RCW'(RECOVER_CYCLES - 1);

  fsm_e           fsm_q, fsm_d;
  logic [SW-1:0]  curr_state_q, curr_state_d;
  logic [FW-1:0]  flag_q, flag_d;
  logic           pulse_q, pulse_d;
  logic           sticky_q, sticky_d;
  logic [CW-1:0]  count_q, count_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;

  logic           upd_legal;
  logic [FW-1:0]  upd_flag;

  state_flag_decode #(
    .SW         (SW),
    .FW         (FW),
    .LEGAL_MASK (LEGAL_MASK),
    .FLAG_TABLE (FLAG_TABLE)
  ) u_decode (
    .state_idx (bus.upd_state),
    .legal     (upd_legal),
    .flag      (upd_flag)
  );

  // State register; reset lands in RUN at the safe state with errors cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= RUN;
      curr_state_q <= SAFE_IDX;
      flag_q       <= SAFE_FLAG;
      pulse_q      <= 1'b0;
      sticky_q     <= 1'b0;
      count_q      <= '0;
      rcnt_q       <= '0;
    end else begin
      fsm_q        <= fsm_d;
      curr_state_q <= curr_state_d;
      flag_q       <= flag_d;
      pulse_q      <= pulse_d;
      sticky_q     <= sticky_d;
      count_q      <= count_d;
      rcnt_q       <= rcnt_d;
    end
  end

  // Next-state logic: accept in RUN, then FAULT for one cycle, then count out RECOVER.
  always_comb begin
    fsm_d        = fsm_q;
    curr_state_d = curr_state_q;
    flag_d       = flag_q;
    pulse_d      = 1'b0;
    sticky_d     = bus.err_clr ? 1'b0 : sticky_q;
    count_d      = bus.err_clr ? '0 : count_q;
    rcnt_d       = rcnt_q;

    case (fsm_q)
      RUN: begin
        if (bus.upd_valid) begin
          if (upd_legal) begin
            curr_state_d = bus.upd_state;
            flag_d       = upd_flag;
          end else begin
            // An illegal accept outranks a simultaneous err_clr.
            curr_state_d = SAFE_IDX;
            flag_d       = ERR_FLAG;
            pulse_d      = 1'b1;
            sticky_d     = 1'b1;
            if (bus.err_clr)
              count_d = CW'(1);
            else if (count_q != '1)
              count_d = count_q + CW'(1);
            fsm_d        = FAULT;
          end
        end
      end
      FAULT: begin
        rcnt_d = RCNT_LOAD;
        fsm_d  = RECOVER;
      end
      RECOVER: begin
        if (rcnt_q == '0) begin
          fsm_d  = RUN;
          flag_d = SAFE_FLAG;
        end else begin
          rcnt_d = rcnt_q - RCW'(1);
        end
      end
      default: begin
        fsm_d        = RUN;
        curr_state_d = SAFE_IDX;
        flag_d       = SAFE_FLAG;
      end
    endcase
  end

  // Outputs come straight from registers; no input reaches an output combinationally.
  always_comb begin
    bus.upd_ready     = (fsm_q == RUN);
    bus.busy          = (fsm_q != RUN);
    bus.curr_state    = curr_state_q;
    bus.flag          = flag_q;
    bus.illegal_pulse = pulse_q;
    bus.err_sticky    = sticky_q;
    bus.err_count     = count_q;
  end

endmodule

// File: tb/tb_state_flag_tracker.sv
// Directed bench for state_flag_tracker with default parameters.
module tb_state_flag_tracker;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  state_flag_tracker_if #(.SW(2), .FW(2), .CW(4)) bus ();

  state_flag_tracker #(
    .SW             (2),
    .FW             (2),
    .LEGAL_MASK     (4'b1011),
    .FLAG_TABLE     (8'h0A),
    .SAFE_STATE     (0),
    .ERR_FLAG       (2'b11),
    .RECOVER_CYCLES (3),
    .CW             (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits at negedges until upd_ready rises; returns the number of low cycles seen.
  task automatic wait_ready(output int low_cycles);
    low_cycles = 0;
    while (bus.upd_ready !== 1'b1 && low_cycles < 20) begin
      chk("flag_in_recovery", 32'(bus.flag), 32'h3);
      low_cycles++;
      step();
    end
    if (bus.upd_ready !== 1'b1) chk("ready_timeout", 32'(bus.upd_ready), 32'h1);
  endtask

  task automatic illegal_update(input logic err_clr_too);
    int lc;
    bus.upd_valid = 1'b1;
    bus.upd_state = 2'b10;
    bus.err_clr   = err_clr_too;
    step();
    bus.upd_valid = 1'b0;
    bus.err_clr   = 1'b0;
    wait_ready(lc);
  endtask

  initial begin
    int lc;
    n_cmp = 0;
    n_bad = 0;
    bus.upd_valid = 1'b0;
    bus.upd_state = 2'b00;
    bus.err_clr   = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_state",  32'(bus.curr_state), 32'h0);
    chk("rst_flag",   32'(bus.flag), 32'h2);
    chk("rst_ready",  32'(bus.upd_ready), 32'h1);
    chk("rst_busy",   32'(bus.busy), 32'h0);
    chk("rst_pulse",  32'(bus.illegal_pulse), 32'h0);
    chk("rst_sticky", 32'(bus.err_sticky), 32'h0);
    chk("rst_count",  32'(bus.err_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Legal sequence 00, 01, 11.
    bus.upd_valid = 1'b1;
    bus.upd_state = 2'b00; step();
    chk("leg0_flag", 32'(bus.flag), 32'h2);
    chk("leg0_state", 32'(bus.curr_state), 32'h0);
    bus.upd_state = 2'b01; step();
    chk("leg1_flag", 32'(bus.flag), 32'h2);
    chk("leg1_state", 32'(bus.curr_state), 32'h1);
    chk("leg1_ready", 32'(bus.upd_ready), 32'h1);
    bus.upd_state = 2'b11; step();
    chk("leg3_flag", 32'(bus.flag), 32'h0);
    chk("leg3_state", 32'(bus.curr_state), 32'h3);
    chk("leg3_ready", 32'(bus.upd_ready), 32'h1);
    chk("leg_count", 32'(bus.err_count), 32'h0);
    bus.upd_valid = 1'b0;

    // Illegal update 10: fault, recovery window of 4 cycles.
    bus.upd_valid = 1'b1;
    bus.upd_state = 2'b10; step();
    bus.upd_valid = 1'b0;
    chk("ill_state",  32'(bus.curr_state), 32'h0);
    chk("ill_flag",   32'(bus.flag), 32'h3);
    chk("ill_pulse",  32'(bus.illegal_pulse), 32'h1);
    chk("ill_sticky", 32'(bus.err_sticky), 32'h1);
    chk("ill_count",  32'(bus.err_count), 32'h1);
    chk("ill_busy",   32'(bus.busy), 32'h1);
    step();
    chk("pulse_one_cycle", 32'(bus.illegal_pulse), 32'h0);
    wait_ready(lc);
    chk("ready_low_cycles", 32'(lc + 1), 32'd4);
    chk("rec_flag", 32'(bus.flag), 32'h2);
    chk("rec_busy", 32'(bus.busy), 32'h0);

    // Update held during recovery is taken on the first ready cycle.
    bus.upd_valid = 1'b1;
    bus.upd_state = 2'b10; step();
    bus.upd_state = 2'b11;
    lc = 0;
    while (bus.upd_ready !== 1'b1 && lc < 20) begin
      chk("held_not_taken", 32'(bus.curr_state), 32'h0);
      lc++;
      step();
    end
    chk("held_wait", 32'(lc), 32'd4);
    step();
    bus.upd_valid = 1'b0;
    chk("held_state", 32'(bus.curr_state), 32'h3);
    chk("held_flag",  32'(bus.flag), 32'h0);
    chk("cnt_two",    32'(bus.err_count), 32'h2);

    // Saturation: 14 more makes 16 illegal updates in total.
    for (int i = 0; i < 14; i++) illegal_update(1'b0);
    chk("sat_count", 32'(bus.err_count), 32'hF);
    illegal_update(1'b0);
    chk("sat_hold", 32'(bus.err_count), 32'hF);
    bus.err_clr = 1'b1; step();
    bus.err_clr = 1'b0;
    chk("clr_sticky", 32'(bus.err_sticky), 32'h0);
    chk("clr_count",  32'(bus.err_count), 32'h0);
    chk("clr_flag",   32'(bus.flag), 32'h2);
    chk("clr_ready",  32'(bus.upd_ready), 32'h1);

    // err_clr together with an illegal accept.
    bus.upd_valid = 1'b1;
    bus.upd_state = 2'b10;
    bus.err_clr   = 1'b1; step();
    bus.upd_valid = 1'b0;
    bus.err_clr   = 1'b0;
    chk("clrill_sticky", 32'(bus.err_sticky), 32'h1);
    chk("clrill_count",  32'(bus.err_count), 32'h1);
    wait_ready(lc);

    // Asynchronous reset two cycles into RECOVER.
    bus.upd_valid = 1'b1;
    bus.upd_state = 2'b10; step();
    bus.upd_valid = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_busy", 32'(bus.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready",  32'(bus.upd_ready), 32'h1);
    chk("arst_busy",   32'(bus.busy), 32'h0);
    chk("arst_flag",   32'(bus.flag), 32'h2);
    chk("arst_state",  32'(bus.curr_state), 32'h0);
    chk("arst_sticky", 32'(bus.err_sticky), 32'h0);
    chk("arst_count",  32'(bus.err_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.upd_valid = 1'b1;
    bus.upd_state = 2'b01; step();
    chk("post_rst_state", 32'(bus.curr_state), 32'h1);
    chk("post_rst_flag",  32'(bus.flag), 32'h2);
    bus.upd_state = 2'b11; step();
    bus.upd_valid = 1'b0;
    chk("post_rst_flag3", 32'(bus.flag), 32'h0);
    chk("post_rst_ready", 32'(bus.upd_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
